matrix_add_engine: RTL
======================

# matrix_add_engine

- Bus-slave arithmetic stage that sits downstream of the execution unit on the shared 256-bit matrix bus.
- Execution writes two 4x4 matrices of 16-bit unsigned elements, then starts the engine; the engine sums them element by element, one element per clock, in a sequential datapath.
- Execution then reads back the 256-bit result and a status word.

## Interface
- BASE_ADDR, default 16'h3000: decode base. Offsets: +0 operand A, +1 operand B, +2 result (read-only), +3 control/status. All other addresses are not selected.
- Clk  in  1  system clock; everything is sampled on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- DataOut  out  256  registered read data; drives the dedicated ALU-output net.
- DataIn  in  256  write data from the execution unit.
- address  in  16  bus address.
- nRead  in  1  active-low read strobe.
- nWrite  in  1  active-low write strobe.

## Operation
- Element i occupies bits [16i+15:16i], for i = 0..15.
- Write to A or B (nWrite low, address matches): the register loads DataIn at the clock edge. The write is ignored while busy.
- Write to CTRL with DataIn[0]=1 while IDLE is a start:
  - state <= ADD, cnt <= 0.
  - result <= 0, carry mask <= 0, done <= 0.
- A start while busy is ignored. CTRL writes with DataIn[0]=0 have no effect. Writes to RESULT are ignored.
- FSM states: IDLE, ADD.
  - IDLE -> ADD on start.
  - In ADD, each edge: result[cnt] <= A[cnt] + B[cnt] (mod 2^16); mask[cnt] <= carry-out; cnt <= cnt + 1.
  - When cnt = 15: state <= IDLE, done <= 1 on the same edge.
- cnt is 4 bits. It must never wrap inside a single operation.
- Status word:
  - bit0 busy (state == ADD), bit1 done.
  - bits[31:16] carry mask (bit i = element i overflowed).
  - bits[35:32] cnt; the rest are 0.
- Read (nRead low, address matches): DataOut <= the selected register at the edge. Otherwise DataOut <= 0 at the edge.
- A read of RESULT during ADD returns the partial result: completed elements hold sums, the rest are 0.
- nRead and nWrite both low in the same cycle: both actions occur. The read returns the pre-write value.
- Reset (asynchronous, any time, including mid-ADD) clears:
  - A, B, result, mask, cnt and done to 0.
  - state to IDLE and DataOut to 0.
- Release of nReset takes effect at the next clock edge.

## Timing
- Start captured at edge N. Element k is written at edge N+1+k.
- At edge N+16, done=1 and busy=0. Compute latency is 16 cycles.
- Read latency is 1 cycle: data appears after the edge at which nRead was sampled low. The bus holds address and nRead for that edge.
- A back-to-back start is legal at edge N+17 or later. A start at edge N+16 sees busy and is ignored.
- No operand double-buffering: A and B must stay stable through ADD. This is guaranteed by ignoring writes while busy.

## Configuration
- MATRIX_ADD_SAT_EN defined: each element sum saturates to 16'hFFFF on carry-out. The mask bit is still set.
- MATRIX_ADD_SAT_EN not defined: the sum wraps modulo 2^16. The mask bit is set on carry.
- Timing, FSM and status layout are identical in both builds.

## Test plan
- Reset values:
  - Stimulus: assert nReset low mid-ADD (edge N+5).
  - Response: DataOut, status and result all read 0; busy=0; a subsequent RESULT read returns 0.
- Basic add:
  - Stimulus: A element i = i, B element i = 16'h0100 + i, start.
  - Response: at N+16 done=1; RESULT element i = 16'h0100 + 2i; mask = 0.
- Overflow:
  - Stimulus: A all 16'hFFF0, B element0 = 16'h0020, other B elements 0.
  - Response: element0 = 16'h0010 (wrap) or 16'hFFFF (with SAT_EN); other elements 16'hFFF0; mask = 16'h0001.
- Busy protection:
  - Stimulus: start, then at N+3 write B = all 16'h7777 and issue a second start.
  - Response: both are ignored; the result matches the original operands; done occurs at N+16, not later.
- Partial read:
  - Stimulus: read RESULT sampled at edge N+4.
  - Response: elements 0..2 hold sums and elements 3..15 are 0. Status cnt reads 3 if STATUS is read at the same edge.
- Decode:
  - Stimulus: write BASE_ADDR+4, then read it.
  - Response: no register changes; DataOut = 0.

Source files
------------

// File: rtl/matrix_add_engine.sv
// ============================================================================
// matrix_add_engine
// ----------------------------------------------------------------------------
// Bus-slave arithmetic stage on the shared 256-bit matrix bus. The execution
// unit writes two 4x4 matrices of 16-bit unsigned elements (operand A and
// operand B), then starts the engine. The engine adds them element by element,
// one element per clock, and records a carry-out mask. The execution unit
// then reads back the 256-bit result and a status word.
//
// Element i of any 256-bit matrix word occupies bits [16i+15:16i], i = 0..15.
//
// Register map (word offsets from BASE_ADDR):
//   +0  operand A        read/write (writes ignored while busy)
//   +1  operand B        read/write (writes ignored while busy)
//   +2  result           read-only  (partial during ADD, unfinished = 0)
//   +3  control/status   write DataIn[0]=1 while idle starts an add
//                        read: bit0 busy, bit1 done, [31:16] carry mask,
//                              [35:32] element counter, others 0
//
// Ports:
//   Clk      in   1    system clock, rising-edge active
//   nReset   in   1    asynchronous active-low reset
//   DataOut  out  256  registered read data (0 when no read is selected)
//   DataIn   in   256  write data
//   address  in   16   bus address
//   nRead    in   1    active-low read strobe
//   nWrite   in   1    active-low write strobe
//
// Build option:
//   MATRIX_ADD_SAT_EN  when defined, an element sum that carries out
//                      saturates to 16'hFFFF; otherwise it wraps modulo 2^16.
//                      The carry mask bit is set in both builds.
// ============================================================================
module matrix_add_engine #(
    parameter logic [15:0] BASE_ADDR = 16'h3000
) (
    input  logic         Clk,
    input  logic         nReset,
    output logic [255:0] DataOut,
    input  logic [255:0] DataIn,
    input  logic [15:0]  address,
    input  logic         nRead,
    input  logic         nWrite
);

    // ------------------------------------------------------------------------
    // Register offsets and FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] OFF_A    = 2'd0;
    localparam logic [1:0] OFF_B    = 2'd1;
    localparam logic [1:0] OFF_RES  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Element arithmetic helpers
    // ------------------------------------------------------------------------
    // Returns {carry_out, sum[15:0]} of a 16-bit unsigned add.
    function automatic logic [16:0] elem_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        elem_add = {1'b0, a} + {1'b0, b};
    endfunction

    // Applies the build-selected overflow policy to a raw 17-bit sum.
    function automatic logic [15:0] elem_policy(input logic [16:0] raw);
`ifdef MATRIX_ADD_SAT_EN
        if (raw[16]) begin
            elem_policy = 16'hFFFF;
        end else begin
            elem_policy = raw[15:0];
        end
`else
        elem_policy = raw[15:0];
`endif
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t         r_state;
    logic [255:0]   r_a;
    logic [255:0]   r_b;
    logic [255:0]   r_result;
    logic [15:0]    r_mask;
    logic [3:0]     r_cnt;
    logic           r_done;
    logic [255:0]   r_dataout;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    state_t         w_state_nxt;
    logic [15:0]    w_offset;
    logic           w_sel;
    logic [1:0]     w_reg;
    logic           w_wr;
    logic           w_rd;
    logic           w_busy;
    logic           w_start;
    logic           w_wr_a;
    logic           w_wr_b;
    logic [7:0]     w_lsb;
    logic [15:0]    w_a_elem;
    logic [15:0]    w_b_elem;
    logic [16:0]    w_raw_sum;
    logic [15:0]    w_sum;
    logic           w_carry;
    logic           w_last;
    logic [255:0]   w_status;
    logic [255:0]   w_rd_data;

    // Address decode: the subtraction makes any BASE_ADDR alignment legal and
    // everything outside the four-word window deselected.
    assign w_offset = address - BASE_ADDR;
    assign w_sel    = (w_offset < 16'd4);
    assign w_reg    = w_offset[1:0];
    assign w_wr     = w_sel & ~nWrite;
    assign w_rd     = w_sel & ~nRead;

    assign w_busy   = (r_state == ST_ADD);

    // Starts and operand writes are dropped while busy so A and B stay stable
    // for the whole operation (there is no operand double buffer).
    assign w_start  = w_wr & (w_reg == OFF_CTRL) & DataIn[0] & ~w_busy;
    assign w_wr_a   = w_wr & (w_reg == OFF_A) & ~w_busy;
    assign w_wr_b   = w_wr & (w_reg == OFF_B) & ~w_busy;

    // Current element slice selected by the counter.
    assign w_lsb     = {r_cnt, 4'b0000};
    assign w_a_elem  = r_a[w_lsb +: 16];
    assign w_b_elem  = r_b[w_lsb +: 16];
    assign w_raw_sum = elem_add(w_a_elem, w_b_elem);
    assign w_sum     = elem_policy(w_raw_sum);
    assign w_carry   = w_raw_sum[16];
    assign w_last    = (r_cnt == 4'd15);

    assign w_status  = {220'd0, r_cnt, r_mask, 14'd0, r_done, w_busy};

    assign DataOut   = r_dataout;

    // Next-state logic of the IDLE/ADD sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_ADD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ADD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read-data mux; unselected or idle bus cycles return zero.
    always_comb begin
        w_rd_data = 256'd0;
        if (w_rd) begin
            case (w_reg)
                OFF_A:    w_rd_data = r_a;
                OFF_B:    w_rd_data = r_b;
                OFF_RES:  w_rd_data = r_result;
                OFF_CTRL: w_rd_data = w_status;
                default:  w_rd_data = 256'd0;
            endcase
        end else begin
            w_rd_data = 256'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers, loaded from the bus while idle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_a <= 256'd0;
            r_b <= 256'd0;
        end else begin
            if (w_wr_a) begin
                r_a <= DataIn;
            end
            if (w_wr_b) begin
                r_b <= DataIn;
            end
        end
    end

    // Sequential adder: one element per clock, result and carry mask are
    // cleared at start so a mid-operation read shows zeros for pending slots.
    // The counter stops at 15 on the final edge rather than wrapping.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_result <= 256'd0;
            r_mask   <= 16'd0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
        end else if (w_start) begin
            r_result <= 256'd0;
            r_mask   <= 16'd0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
        end else if (w_busy) begin
            r_result[w_lsb +: 16] <= w_sum;
            r_mask[r_cnt]         <= w_carry;
            if (w_last) begin
                r_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

    // Registered read data; reads sample pre-edge register values, so a
    // simultaneous write is not visible until the following read.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_dataout <= 256'd0;
        end else begin
            r_dataout <= w_rd_data;
        end
    end

endmodule
